// File: rtl/hx8357_pkg.sv
// Shared types and constants for the HX8357 8080-style write-only bus driver.
package hx8357_pkg;

    typedef enum logic [2:0] {
        RES_LOW,
        RES_WAIT,
        IDLE,
        REQ,
        SETUP,
        WR_LOW,
        WR_HIGH,
        DONE
    } state_e;

    localparam int DEF_RESX_LOW_CYCLES  = 250;
    localparam int DEF_RESX_WAIT_CYCLES = 125000;
    localparam int DEF_WR_LOW_CYCLES    = 1;
    localparam int DEF_WR_HIGH_CYCLES   = 1;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hx8357_delay_counter.sv
// Loadable down-counter with zero flag, shared by the reset and strobe phases.
module hx8357_delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hx8357_controller.sv
// HX8357 write-only 8080 bus driver: panel reset sequence, then timed
// command/data write cycles with a supply_data / transmission_cmpl handshake.
module hx8357_controller
    import hx8357_pkg::*;
#(
    parameter int RESX_LOW_CYCLES  = DEF_RESX_LOW_CYCLES,
    parameter int RESX_WAIT_CYCLES = DEF_RESX_WAIT_CYCLES,
    parameter int WR_LOW_CYCLES    = DEF_WR_LOW_CYCLES,
    parameter int WR_HIGH_CYCLES   = DEF_WR_HIGH_CYCLES
) (
    input  logic        clk,
    input  logic        nres,
    input  logic [15:0] data_in,
    input  logic        cmd,
    input  logic        data,
    output logic        supply_data,
    output logic        transmission_cmpl,
    output logic        CSx,
    output logic        RESx,
    output logic        DCx,
    output logic        WRx,
    output logic        RDx,
    output logic [15:0] Data
);

    localparam int MAXP  = max4(RESX_LOW_CYCLES, RESX_WAIT_CYCLES, WR_LOW_CYCLES, WR_HIGH_CYCLES);
    localparam int CNT_W = (MAXP > 1) ? $clog2(MAXP) : 1;

    // Counter holds phase length minus one so that zero marks the last cycle.
    localparam logic [CNT_W-1:0] RL_LOAD = CNT_W'(RESX_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RW_LOAD = CNT_W'(RESX_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WL_LOAD = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WH_LOAD = CNT_W'(WR_HIGH_CYCLES - 1);

    state_e            state_q;
    logic              type_q;
    logic              csx_q, resx_q, dcx_q, wrx_q, rdx_q, sd_q, tc_q;
    logic [15:0]       data_q;
    logic              load_s;
    logic [CNT_W-1:0]  load_val_s;
    logic              zero_s;

    hx8357_delay_counter #(.W(CNT_W)) u_delay (
        .clk        (clk),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .zero_o     (zero_s)
    );

    // Counter load requests at each timed-phase entry.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = '0;
        if (nres) begin
            load_s     = 1'b1;
            load_val_s = RL_LOAD;
        end else begin
            case (state_q)
                RES_LOW: begin
                    load_s     = zero_s;
                    load_val_s = RW_LOAD;
                end
                SETUP: begin
                    load_s     = 1'b1;
                    load_val_s = WL_LOAD;
                end
                WR_LOW: begin
                    load_s     = zero_s;
                    load_val_s = WH_LOAD;
                end
                default: begin
                    load_s     = 1'b0;
                    load_val_s = '0;
                end
            endcase
        end
    end

    // Main sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        rdx_q <= 1'b1;
        if (nres) begin
            state_q <= RES_LOW;
            type_q  <= DC_DATA;
            csx_q   <= 1'b1;
            resx_q  <= 1'b0;
            dcx_q   <= 1'b1;
            wrx_q   <= 1'b1;
            data_q  <= 16'h0000;
            sd_q    <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            case (state_q)
                RES_LOW: begin
                    if (zero_s) begin
                        state_q <= RES_WAIT;
                        resx_q  <= 1'b1;
                    end
                end
                RES_WAIT: begin
                    if (zero_s) state_q <= IDLE;
                end
                IDLE, DONE: begin
                    tc_q <= 1'b0;
                    if (cmd) begin
                        state_q <= REQ;
                        type_q  <= DC_CMD;
                        sd_q    <= 1'b1;
                    end else if (data) begin
                        state_q <= REQ;
                        type_q  <= DC_DATA;
                        sd_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        csx_q   <= 1'b1;
                    end
                end
                REQ: begin
                    state_q <= SETUP;
                    sd_q    <= 1'b0;
                    csx_q   <= 1'b0;
                    dcx_q   <= type_q;
                end
                SETUP: begin
                    state_q <= WR_LOW;
                    data_q  <= data_in;
                    wrx_q   <= 1'b0;
                end
                WR_LOW: begin
                    if (zero_s) begin
                        state_q <= WR_HIGH;
                        wrx_q   <= 1'b1;
                    end
                end
                WR_HIGH: begin
                    if (zero_s) begin
                        state_q <= DONE;
                        tc_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= RES_LOW;
                    resx_q  <= 1'b0;
                end
            endcase
        end
    end

    assign supply_data       = sd_q;
    assign transmission_cmpl = tc_q;
    assign CSx               = csx_q;
    assign RESx              = resx_q;
    assign DCx               = dcx_q;
    assign WRx               = wrx_q;
    assign RDx               = rdx_q;
    assign Data              = data_q;

endmodule

// File: tb/tb_hx8357_controller.sv
// Directed self-checking bench for hx8357_controller with a shortened reset sequence.
module tb_hx8357_controller;
    import hx8357_pkg::*;

    logic        clk = 1'b0;
    logic        nres = 1'b1;
    logic        cmd = 1'b0;
    logic        data = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        supply_data, transmission_cmpl, CSx, RESx, DCx, WRx, RDx;
    logic [15:0] Data;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    logic done;

    hx8357_controller #(
        .RESX_LOW_CYCLES  (4),
        .RESX_WAIT_CYCLES (8)
    ) dut (
        .clk               (clk),
        .nres              (nres),
        .data_in           (data_in),
        .cmd               (cmd),
        .data              (data),
        .supply_data       (supply_data),
        .transmission_cmpl (transmission_cmpl),
        .CSx               (CSx),
        .RESx              (RESx),
        .DCx               (DCx),
        .WRx               (WRx),
        .RDx               (RDx),
        .Data              (Data)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge of request cycle t; returns at the negedge of DONE (t+5).
    task automatic run_xfer(input logic exp_dc, input logic [15:0] word, input logic exp_cs_req,
                            input logic nxt_cmd, input logic nxt_data);
        @(negedge clk);
        chk("req_sd", {31'b0, supply_data}, 32'd1);
        chk("req_tc", {31'b0, transmission_cmpl}, 32'd0);
        chk("req_cs", {31'b0, CSx}, {31'b0, exp_cs_req});
        chk("req_wr", {31'b0, WRx}, 32'd1);
        data_in = word;
        cmd     = nxt_cmd;
        data    = nxt_data;
        @(negedge clk);
        chk("setup_cs", {31'b0, CSx}, 32'd0);
        chk("setup_dc", {31'b0, DCx}, {31'b0, exp_dc});
        chk("setup_wr", {31'b0, WRx}, 32'd1);
        chk("setup_sd", {31'b0, supply_data}, 32'd0);
        @(negedge clk);
        chk("wrlow_wr", {31'b0, WRx}, 32'd0);
        chk("wrlow_data", {16'b0, Data}, {16'b0, word});
        chk("wrlow_cs", {31'b0, CSx}, 32'd0);
        chk("wrlow_dc", {31'b0, DCx}, {31'b0, exp_dc});
        @(negedge clk);
        chk("wrhigh_wr", {31'b0, WRx}, 32'd1);
        chk("wrhigh_data", {16'b0, Data}, {16'b0, word});
        chk("wrhigh_tc", {31'b0, transmission_cmpl}, 32'd0);
        @(negedge clk);
        chk("done_tc", {31'b0, transmission_cmpl}, 32'd1);
        chk("done_sd", {31'b0, supply_data}, 32'd0);
        chk("done_cs", {31'b0, CSx}, 32'd0);
        chk("done_data", {16'b0, Data}, {16'b0, word});
        chk("done_rd", {31'b0, RDx}, 32'd1);
    endtask

    initial begin
        repeat (12) @(negedge clk);
        chk("rst_cs", {31'b0, CSx}, 32'd1);
        chk("rst_resx", {31'b0, RESx}, 32'd0);
        chk("rst_dc", {31'b0, DCx}, 32'd1);
        chk("rst_wr", {31'b0, WRx}, 32'd1);
        chk("rst_rd", {31'b0, RDx}, 32'd1);
        chk("rst_data", {16'b0, Data}, 32'd0);
        chk("rst_sd", {31'b0, supply_data}, 32'd0);
        chk("rst_tc", {31'b0, transmission_cmpl}, 32'd0);

        // Release with cmd already requested: it must be ignored until IDLE.
        nres = 1'b0;
        cmd  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("seq_resx", {31'b0, RESx}, (i >= 4) ? 32'd1 : 32'd0);
            chk("seq_sd", {31'b0, supply_data}, 32'd0);
        end

        run_xfer(DC_CMD, 16'h0080, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("cmd_idle_cs", {31'b0, CSx}, 32'd1);
        chk("cmd_idle_sd", {31'b0, supply_data}, 32'd0);

        data = 1'b1;
        run_xfer(DC_DATA, 16'h1234, 1'b1, 1'b0, 1'b1);
        run_xfer(DC_DATA, 16'h5678, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("burst_idle_cs", {31'b0, CSx}, 32'd1);
        chk("burst_idle_data", {16'b0, Data}, 32'h5678);
        chk("burst_idle_dc", {31'b0, DCx}, 32'd1);

        // Request-to-completion latency, bounded.
        data = 1'b1;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (supply_data) begin
                data_in = 16'hBEEF;
                data    = 1'b0;
            end
            chk("no_overlap", {31'b0, supply_data & transmission_cmpl}, 32'd0);
            chk("lat_rd", {31'b0, RDx}, 32'd1);
            if (transmission_cmpl) done = 1'b1;
        end
        chk("lat_timeout", {31'b0, done}, 32'd1);
        chk("latency", lat, 32'd5);
        @(negedge clk);

        // cmd beats data when both are raised together.
        cmd  = 1'b1;
        data = 1'b1;
        run_xfer(DC_CMD, 16'hA5A5, 1'b1, 1'b0, 1'b1);
        run_xfer(DC_DATA, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("prio_idle_cs", {31'b0, CSx}, 32'd1);

        // Abort in WR_LOW.
        cmd = 1'b1;
        @(negedge clk);
        chk("abort_sd", {31'b0, supply_data}, 32'd1);
        data_in = 16'h1111;
        cmd     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_wrlow", {31'b0, WRx}, 32'd0);
        nres = 1'b1;
        @(negedge clk);
        chk("abort_wr", {31'b0, WRx}, 32'd1);
        chk("abort_cs", {31'b0, CSx}, 32'd1);
        chk("abort_resx", {31'b0, RESx}, 32'd0);
        chk("abort_tc", {31'b0, transmission_cmpl}, 32'd0);
        chk("abort_data", {16'b0, Data}, 32'd0);
        @(negedge clk);
        chk("abort_tc2", {31'b0, transmission_cmpl}, 32'd0);
        nres = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
